fpdiv_round_pack: RTL and testbench

//  Downstream stage of the Goldschmidt divider. Captures the 32-bit quotient q (x.xxx, value in (0.5,2)) when the

---
 rtl/fpdiv_round_pack_pkg.sv | 31 +++
 rtl/fpdiv_round_pack_if.sv | 27 ++
 rtl/fpdiv_round_pack_rne_rounder.sv | 20 ++
 rtl/fpdiv_round_pack.sv | 128 ++++++++++++
 tb/tb_fpdiv_round_pack.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fpdiv_round_pack_pkg.sv
// fpdiv_round_pack_pkg: shared constants and types for the divider round/pack stage.
// Class encodings, IEEE single constants, sideband tag and result bundles.
package fpdiv_round_pack_pkg;

  localparam int QW      = 32;
  localparam int EW      = 10;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    CLS_NORM = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } cls_e;

  typedef struct packed {
    logic                 sgn;
    logic signed [EW-1:0] ed;
    cls_e                 cls;
  } tag_t;

  typedef struct packed {
    logic [31:0] f;
    logic        ovf;
    logic        unf;
  } res_t;

endpackage

// File: rtl/fpdiv_round_pack_if.sv
// fpdiv_round_pack_if: valid/ready result channel toward the FPU result mux.
// master drives out_valid/out_f/out_ovf/out_unf, slave drives out_ready.
interface fpdiv_round_pack_if;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic        out_ovf;
  logic        out_unf;

  modport master (
    output out_valid,
    output out_f,
    output out_ovf,
    output out_unf,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_f,
    input  out_ovf,
    input  out_unf,
    output out_ready
  );

endinterface

// File: rtl/fpdiv_round_pack_rne_rounder.sv
// rne_rounder: combinational round-to-nearest-even of a 24-bit significand.
// In: sig_i, guard g_i, sticky s_i. Out: sig24_o (0 on carry), carry_o.
module rne_rounder (
  input  logic [23:0] sig_i,
  input  logic        g_i,
  input  logic        s_i,
  output logic [23:0] sig24_o,
  output logic        carry_o
);

  logic        up;
  logic [24:0] sum;

  assign up      = g_i & (s_i | sig_i[0]);
  assign sum     = {1'b0, sig_i} + {24'd0, up};
  assign carry_o = sum[24];
  // A carry means 1.111..1 rounded to 2.0: mantissa field becomes zero.
  assign sig24_o = sum[24] ? 24'd0 : sum[23:0];

endmodule

// File: rtl/fpdiv_round_pack.sv
// fpdiv_round_pack: captures the Goldschmidt quotient, normalizes, rounds RNE,
// range-checks and packs an IEEE single into a 1-entry valid/ready output (res).
module fpdiv_round_pack
  import fpdiv_round_pack_pkg::*;
(
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 div_start,
  input  logic                 div_ready,
  input  logic [QW-1:0]        div_q,
  input  logic                 sgn_in,
  input  logic signed [EW-1:0] exp_diff,
  input  logic [1:0]           cls_in,
  fpdiv_round_pack_if.master   res,
  output logic                 overrun
);

  logic          rdy_prev_q, rdy_prev_d;
  tag_t          tag_q, tag_d;
  logic          s1_valid_q, s1_valid_d;
  logic [QW-1:0] s1_quo_q, s1_quo_d;
  tag_t          s1_tag_q, s1_tag_d;
  logic          out_valid_q, out_valid_d;
  res_t          out_q, out_d;
  logic          overrun_q, overrun_d;

  logic          cap, load, cap_ok;

  logic [23:0]   sig, sig24;
  logic          g, s, adj1, carry;
  logic [EW-1:0] e_raw;
  logic          e_ovf, e_unf;
  res_t          pk;

  always_comb begin
    cap    = div_ready & ~rdy_prev_q;
    load   = s1_valid_q & (~out_valid_q | res.out_ready);
    // S1 may take a new capture on the same edge it hands off.
    cap_ok = cap & (~s1_valid_q | load);
  end

  always_comb begin
    if (s1_quo_q[31]) begin
      sig  = s1_quo_q[31:8];
      g    = s1_quo_q[7];
      s    = |s1_quo_q[6:0];
      adj1 = 1'b0;
    end else begin
      sig  = s1_quo_q[30:7];
      g    = s1_quo_q[6];
      s    = |s1_quo_q[5:0];
      adj1 = 1'b1;
    end
  end

  rne_rounder u_rne (
    .sig_i   (sig),
    .g_i     (g),
    .s_i     (s),
    .sig24_o (sig24),
    .carry_o (carry)
  );

  always_comb begin
    e_raw = s1_tag_q.ed + EW'(BIAS) - EW'(adj1) + EW'(carry);
    e_ovf = $signed(e_raw) >= $signed(EW'(EXP_MAX));
    e_unf = e_raw[EW-1] | (e_raw == '0);
  end

  always_comb begin
    pk = '0;
    if (s1_tag_q.cls == CLS_NAN) begin
      pk.f = QNAN;
    end else if (s1_tag_q.cls == CLS_INF) begin
      pk.f = {s1_tag_q.sgn, 8'hFF, 23'd0};
    end else if (s1_tag_q.cls == CLS_ZERO) begin
      pk.f = {s1_tag_q.sgn, 31'd0};
    end else if (e_ovf) begin
      pk.f   = {s1_tag_q.sgn, 8'hFF, 23'd0};
      pk.ovf = 1'b1;
    end else if (e_unf) begin
      pk.f   = {s1_tag_q.sgn, 31'd0};
      pk.unf = 1'b1;
    end else begin
      pk.f = {s1_tag_q.sgn, e_raw[7:0], sig24[22:0]};
    end
  end

  always_comb begin
    rdy_prev_d  = div_ready;
    tag_d       = div_start ? {sgn_in, exp_diff, cls_e'(cls_in)} : tag_q;
    s1_valid_d  = cap_ok | (s1_valid_q & ~load);
    s1_quo_d    = cap_ok ? div_q : s1_quo_q;
    s1_tag_d    = cap_ok ? tag_q : s1_tag_q;
    out_valid_d = load | (out_valid_q & ~res.out_ready);
    out_d       = load ? pk : out_q;
    overrun_d   = overrun_q | (cap & ~cap_ok);
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      rdy_prev_q  <= 1'b1;
      tag_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_quo_q    <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      rdy_prev_q  <= rdy_prev_d;
      tag_q       <= tag_d;
      s1_valid_q  <= s1_valid_d;
      s1_quo_q    <= s1_quo_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign res.out_valid = out_valid_q;
  assign res.out_f     = out_q.f;
  assign res.out_ovf   = out_q.ovf;
  assign res.out_unf   = out_q.unf;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fpdiv_round_pack.sv
// tb_fpdiv_round_pack: random + directed check of fpdiv_round_pack
// against a value-level IEEE rounding model.
module tb_fpdiv_round_pack;

  logic              clk = 1'b0;
  logic              clrn;
  logic              div_start;
  logic              div_ready;
  logic [31:0]       div_q;
  logic              sgn_in;
  logic signed [9:0] exp_diff;
  logic [1:0]        cls_in;
  logic              overrun;

  int total = 0;
  int bad   = 0;

  fpdiv_round_pack_if res ();

  fpdiv_round_pack dut (
    .clk       (clk),
    .clrn      (clrn),
    .div_start (div_start),
    .div_ready (div_ready),
    .div_q     (div_q),
    .sgn_in    (sgn_in),
    .exp_diff  (exp_diff),
    .cls_in    (cls_in),
    .res       (res),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Value model: quotient q is q * 2^-31 times 2^ed; round the exact value
  // to 24 significant bits with ties-to-even, then range-check.
  function automatic logic [33:0] model(input bit sg, input int ed,
                                        input bit [1:0] c, input bit [31:0] q);
    longint m, rem, half, qq;
    int nb, k, e;
    logic [7:0] e8;
    logic [22:0] man;
    if (c == 2'b11) return {2'b00, 32'h7FC00000};
    if (c == 2'b10) return {2'b00, sg, 8'hFF, 23'd0};
    if (c == 2'b01) return {2'b00, sg, 31'd0};
    qq = longint'(q);
    nb = 0;
    for (int i = 0; i < 32; i++) if (q[i]) nb = i + 1;
    k    = nb - 24;
    m    = qq >> k;
    rem  = qq & ((64'sd1 <<< k) - 1);
    half = 64'sd1 <<< (k - 1);
    if (rem > half || (rem == half && m[0])) m = m + 1;
    e = ed + 127 + (nb - 32);
    if (m == (64'sd1 <<< 24)) begin
      m = m >>> 1;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, sg, 8'hFF, 23'd0};
    if (e <= 0) return {2'b01, sg, 31'd0};
    e8  = 8'(e);
    man = 23'(m);
    return {2'b00, sg, e8, man};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start, then a 0->1 on div_ready; returns just after the capture edge.
  task automatic issue(input bit sg, input int ed, input bit [1:0] c,
                       input bit [31:0] q);
    div_start = 1'b1;
    sgn_in    = sg;
    exp_diff  = 10'(ed);
    cls_in    = c;
    tick();
    div_start = 1'b0;
    sgn_in    = 1'($urandom);
    exp_diff  = 10'($urandom);
    cls_in    = 2'($urandom);
    tick();
    div_q     = q;
    div_ready = 1'b1;
    tick();
    div_q     = $urandom;
  endtask

  task automatic run_one(input bit sg, input int ed, input bit [1:0] c,
                         input bit [31:0] q, input int stall);
    logic [33:0] e;
    e = model(sg, ed, c, q);
    res.out_ready = (stall == 0);
    issue(sg, ed, c, q);
    chk("lat_early", res.out_valid, 1'b0);
    tick();
    chk("valid", res.out_valid, 1'b1);
    chk("f", res.out_f, e[31:0]);
    chk("flags", {res.out_ovf, res.out_unf}, e[33:32]);
    if (stall > 0) begin
      repeat (stall) tick();
      chk("hold", {res.out_valid, res.out_f, res.out_ovf, res.out_unf},
          {1'b1, e[31:0], e[33:32]});
      res.out_ready = 1'b1;
    end
    tick();
    chk("drain", res.out_valid, 1'b0);
    div_ready = 1'b0;
    tick();
  endtask

  initial begin
    logic [33:0] ea, eb;
    bit [31:0] q;
    int ed;
    bit [1:0] c;
    clrn          = 1'b1;
    div_start     = 1'b0;
    div_ready     = 1'b0;
    div_q         = '0;
    sgn_in        = 1'b0;
    exp_diff      = '0;
    cls_in        = '0;
    res.out_ready = 1'b1;
    repeat (3) tick();
    clrn = 1'b0;
    tick();
    chk("rst_valid", res.out_valid, 1'b0);
    chk("rst_f", res.out_f, 32'd0);
    chk("rst_flags", {res.out_ovf, res.out_unf}, 2'b00);
    chk("rst_ovr", overrun, 1'b0);

    run_one(1'b0, 1, 2'b00, 32'h80000000, 0);
    run_one(1'b0, 0, 2'b00, 32'h55555555, 0);
    run_one(1'b0, 0, 2'b00, 32'hFFFFFFFF, 2);
    run_one(1'b0, 128, 2'b00, 32'h80000000, 0);
    run_one(1'b1, -127, 2'b00, 32'h40000000, 0);
    run_one(1'b0, 5, 2'b11, 32'h80000000, 0);
    run_one(1'b1, 5, 2'b10, 32'h80000000, 0);
    run_one(1'b0, 5, 2'b01, 32'hC0000000, 1);
    run_one(1'b0, 0, 2'b00, 32'h40000080, 0);
    run_one(1'b0, 0, 2'b00, 32'h80000180, 0);

    // Back-pressure: first held in out, second in S1, third dropped.
    ea = model(1'b0, 3, 2'b00, 32'hA0000000);
    eb = model(1'b1, -2, 2'b00, 32'h60000001);
    res.out_ready = 1'b0;
    issue(1'b0, 3, 2'b00, 32'hA0000000);
    div_ready = 1'b0;
    repeat (7) tick();
    issue(1'b1, -2, 2'b00, 32'h60000001);
    div_ready = 1'b0;
    repeat (7) tick();
    chk("bp_no_ovr", overrun, 1'b0);
    issue(1'b0, 9, 2'b00, 32'hF0000000);
    div_ready = 1'b0;
    tick();
    chk("bp_ovr", overrun, 1'b1);
    chk("bp_first", {res.out_valid, res.out_f}, {1'b1, ea[31:0]});
    res.out_ready = 1'b1;
    tick();
    chk("bp_second", {res.out_valid, res.out_f}, {1'b1, eb[31:0]});
    tick();
    chk("bp_empty", res.out_valid, 1'b0);
    chk("bp_sticky", overrun, 1'b1);

    // Reset one cycle after a capture with div_ready held high.
    issue(1'b0, 1, 2'b00, 32'h80000000);
    clrn = 1'b1;
    tick();
    clrn = 1'b0;
    chk("rr_valid", res.out_valid, 1'b0);
    chk("rr_ovr", overrun, 1'b0);
    repeat (5) tick();
    chk("rr_nocap", res.out_valid, 1'b0);
    div_ready = 1'b0;
    tick();
    run_one(1'b1, 7, 2'b00, 32'hB3333333, 0);

    for (int n = 0; n < 40; n++) begin
      q = $urandom;
      if (q[31:30] == 2'b00) q[30] = 1'b1;
      if (n % 5 == 0) q[6:0] = 7'h40;
      ed = int'($urandom_range(280)) - 140;
      c  = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      run_one(1'($urandom), ed, c, q, int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
